// File: rtl/neokeon_decrypt_core.sv
// NOEKEON-128 iterative decryptor: one inverse round per clock, working key derived internally.
// Latency: 19 cycles from accepted start to the outValid pulse (18 on a key-cache hit).
// No backpressure: starts arriving while busy are dropped; result held until the next one completes.
// Optional: define NEOKEON_KEY_CACHE_EN to keep the last key/working key and skip KEYPREP on a match.
module neokeon_decrypt_core #(
    parameter int         NROUNDS = 16,
    parameter logic [7:0] RC_INIT = 8'h80
) (
    input  logic         inClk,
    input  logic         inRstN,
    input  logic         inStart,
    input  logic [127:0] inKey,
    input  logic [127:0] inDataBlock,
    output logic         outBusy,
    output logic         outValid,
    output logic [127:0] outputData
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEYPREP,
        ST_ROUND,
        ST_FINAL,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [127:0]  key_q, key_d;
    logic [127:0]  wk_q, wk_d;
    logic [127:0]  a_q, a_d;
    logic [127:0]  dout_q, dout_d;
    logic          busy_q, busy_d;
    logic          vld_q, vld_d;
`ifdef NEOKEON_KEY_CACHE_EN
    logic          cache_vld_q, cache_vld_d;
`endif

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Column mix shared by both halves of Theta.
    function automatic logic [31:0] mix(input logic [31:0] t);
        return t ^ rotl32(t, 8) ^ rotl32(t, 24);
    endfunction

    function automatic logic [127:0] theta(input logic [127:0] k, input logic [127:0] a);
        logic [31:0] a0, a1, a2, a3, t;
        {a0, a1, a2, a3} = a;
        t  = mix(a0 ^ a2);
        a1 = a1 ^ t;
        a3 = a3 ^ t;
        a0 = a0 ^ k[127:96];
        a1 = a1 ^ k[95:64];
        a2 = a2 ^ k[63:32];
        a3 = a3 ^ k[31:0];
        t  = mix(a1 ^ a3);
        a0 = a0 ^ t;
        a2 = a2 ^ t;
        return {a0, a1, a2, a3};
    endfunction

    function automatic logic [127:0] pi1(input logic [127:0] a);
        return {a[127:96], rotl32(a[95:64], 1), rotl32(a[63:32], 5), rotl32(a[31:0], 2)};
    endfunction

    function automatic logic [127:0] pi2(input logic [127:0] a);
        return {a[127:96], rotl32(a[95:64], 31), rotl32(a[63:32], 27), rotl32(a[31:0], 30)};
    endfunction

    function automatic logic [127:0] gamma(input logic [127:0] a);
        logic [31:0] a0, a1, a2, a3, tmp;
        {a0, a1, a2, a3} = a;
        a1  = a1 ^ (~a3 & ~a2);
        a0  = a0 ^ (a2 & a1);
        tmp = a3;
        a3  = a0;
        a0  = tmp;
        a2  = a2 ^ a0 ^ a1 ^ a3;
        a1  = a1 ^ (~a3 & ~a2);
        a0  = a0 ^ (a2 & a1);
        return {a0, a1, a2, a3};
    endfunction

    // Round-constant ROM: RC[idx] = xtime^idx(RC_INIT), unrolled over a fixed bound.
    function automatic logic [7:0] rc_of(input logic [4:0] idx);
        logic [7:0] r;
        r = RC_INIT;
        for (int j = 1; j <= NROUNDS; j++) begin
            if (5'(j) <= idx) begin
                r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rc_mask(input logic [7:0] rc);
        return {24'h0, rc, 96'h0};
    endfunction

    function automatic logic [127:0] inv_round(input logic [127:0] a, input logic [127:0] wk,
                                               input logic [7:0] rc);
        return pi2(gamma(pi1(theta(wk, a) ^ rc_mask(rc))));
    endfunction

    // Next-state and datapath: sequences KEYPREP, 16 inverse rounds, final Theta and result hand-off.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        wk_d    = wk_q;
        a_d     = a_q;
        dout_d  = dout_q;
        busy_d  = busy_q;
        vld_d   = 1'b0;
`ifdef NEOKEON_KEY_CACHE_EN
        cache_vld_d = cache_vld_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (inStart) begin
                    key_d  = inKey;
                    a_d    = inDataBlock;
                    busy_d = 1'b1;
`ifdef NEOKEON_KEY_CACHE_EN
                    if (cache_vld_q && (inKey == key_q)) begin
                        state_d = ST_ROUND;
                        cnt_d   = 5'(NROUNDS);
                    end else begin
                        state_d = ST_KEYPREP;
                    end
`else
                    state_d = ST_KEYPREP;
`endif
                end
            end
            ST_KEYPREP: begin
                wk_d    = theta(128'h0, key_q);
                cnt_d   = 5'(NROUNDS);
                state_d = ST_ROUND;
`ifdef NEOKEON_KEY_CACHE_EN
                cache_vld_d = 1'b1;
`endif
            end
            ST_ROUND: begin
                if ((cnt_q == 5'd0) || (cnt_q > 5'(NROUNDS))) begin
                    // Unreachable count: abandon the block rather than run an undefined round.
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    a_d   = inv_round(a_q, wk_q, rc_of(cnt_q));
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_d = ST_FINAL;
                    end
                end
            end
            ST_FINAL: begin
                a_d     = theta(wk_q, a_q) ^ rc_mask(rc_of(5'd0));
                state_d = ST_DONE;
            end
            ST_DONE: begin
                dout_d  = a_q;
                vld_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, key, data and output registers; reset clears everything including the key cache.
    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            key_q   <= 128'h0;
            wk_q    <= 128'h0;
            a_q     <= 128'h0;
            dout_q  <= 128'h0;
            busy_q  <= 1'b0;
            vld_q   <= 1'b0;
`ifdef NEOKEON_KEY_CACHE_EN
            cache_vld_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            wk_q    <= wk_d;
            a_q     <= a_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            vld_q   <= vld_d;
`ifdef NEOKEON_KEY_CACHE_EN
            cache_vld_q <= cache_vld_d;
`endif
        end
    end

    assign outBusy    = busy_q;
    assign outValid   = vld_q;
    assign outputData = dout_q;

endmodule

// File: tb/tb_neokeon_decrypt_core.sv
// Bench for neokeon_decrypt_core: word-level NOEKEON model, per-cycle compare of all outputs,
// directed plan scenarios plus randomized blocks and a continuously-held start.
// Honours NEOKEON_KEY_CACHE_EN for the expected latency on repeated keys.
module tb_neokeon_decrypt_core;

`ifdef NEOKEON_KEY_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    typedef logic [0:3][31:0] st_t;   // element 0 is a0 (most significant word)

    logic         inClk = 1'b0;
    logic         inRstN = 1'b1;
    logic         inStart = 1'b0;
    logic [127:0] inKey = '0;
    logic [127:0] inDataBlock = '0;
    logic         outBusy;
    logic         outValid;
    logic [127:0] outputData;

    int vectors = 0;
    int miscompares = 0;

    neokeon_decrypt_core dut (
        .inClk       (inClk),
        .inRstN      (inRstN),
        .inStart     (inStart),
        .inKey       (inKey),
        .inDataBlock (inDataBlock),
        .outBusy     (outBusy),
        .outValid    (outValid),
        .outputData  (outputData)
    );

    always #5 inClk = ~inClk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x};
        return d[63 - n -: 32];
    endfunction

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return rl(x, 32 - n);
    endfunction

    function automatic logic [7:0] m_rc(input int i);
        int r;
        r = 128;
        repeat (i) begin
            r = r * 2;
            if (r > 255) r = r ^ 'h11B;
        end
        return 8'(r);
    endfunction

    function automatic st_t m_theta(input st_t k, input st_t a);
        logic [31:0] t;
        t = a[0] ^ a[2];
        t = t ^ rl(t, 8) ^ rr(t, 8);
        a[1] ^= t;
        a[3] ^= t;
        for (int i = 0; i < 4; i++) a[i] ^= k[i];
        t = a[1] ^ a[3];
        t = t ^ rl(t, 8) ^ rr(t, 8);
        a[0] ^= t;
        a[2] ^= t;
        return a;
    endfunction

    function automatic st_t m_pi1(input st_t a);
        a[1] = rl(a[1], 1); a[2] = rl(a[2], 5); a[3] = rl(a[3], 2);
        return a;
    endfunction

    function automatic st_t m_pi2(input st_t a);
        a[1] = rr(a[1], 1); a[2] = rr(a[2], 5); a[3] = rr(a[3], 2);
        return a;
    endfunction

    function automatic st_t m_gamma(input st_t a);
        logic [31:0] s;
        a[1] ^= ~a[3] & ~a[2];
        a[0] ^= a[2] & a[1];
        s = a[0]; a[0] = a[3]; a[3] = s;
        a[2] ^= a[0] ^ a[1] ^ a[3];
        a[1] ^= ~a[3] & ~a[2];
        a[0] ^= a[2] & a[1];
        return a;
    endfunction

    function automatic logic [127:0] m_dec(input logic [127:0] key, input logic [127:0] ct);
        st_t wk, a;
        wk = m_theta(st_t'(128'h0), st_t'(key));
        a  = st_t'(ct);
        for (int i = 16; i >= 1; i--) begin
            a = m_theta(wk, a);
            a[0][7:0] ^= m_rc(i);
            a = m_pi2(m_gamma(m_pi1(a)));
        end
        a = m_theta(wk, a);
        a[0][7:0] ^= m_rc(0);
        return a;
    endfunction

    function automatic logic [127:0] m_enc(input logic [127:0] key, input logic [127:0] pt);
        st_t a;
        a = st_t'(pt);
        for (int i = 0; i < 16; i++) begin
            a[0][7:0] ^= m_rc(i);
            a = m_theta(st_t'(key), a);
            a = m_pi2(m_gamma(m_pi1(a)));
        end
        a[0][7:0] ^= m_rc(16);
        a = m_theta(st_t'(key), a);
        return a;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Transaction-level timing model: cycles remaining until the result, plus the key cache.
    int           m_left = 0;
    logic         m_vld = 1'b0;
    logic [127:0] m_data = '0;
    logic [127:0] m_res = '0;
    logic [127:0] m_ckey = '0;
    logic         m_cvld = 1'b0;

    always @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            m_left <= 0;
            m_vld  <= 1'b0;
            m_data <= '0;
            m_cvld <= 1'b0;
            m_ckey <= '0;
        end else begin
            m_vld <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_vld  <= 1'b1;
                    m_data <= m_res;
                end
                if (m_left == 19) m_cvld <= 1'b1;   // key preparation finished
            end else if (inStart) begin
                m_res  <= m_dec(inKey, inDataBlock);
                m_left <= (CACHE && m_cvld && (inKey == m_ckey)) ? 18 : 19;
                m_ckey <= inKey;
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge inClk) begin
        vectors++;
        if (outBusy !== (m_left != 0) || outValid !== m_vld || outputData !== m_data) begin
            miscompares++;
            $display("FAIL cycle t=%0t busy=%b want %b valid=%b want %b data=%h want %h",
                     $time, outBusy, (m_left != 0), outValid, m_vld, outputData, m_data);
        end
    end

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got %h want %h", nm, got, exp);
        end
    endtask

    // Drive one start pulse, scramble the inputs afterwards, wait (bounded) for outValid.
    task automatic run_op(input logic [127:0] key, input logic [127:0] data,
                          output int lat, output logic [127:0] res);
        @(negedge inClk);
        inKey = key; inDataBlock = data; inStart = 1'b1;
        @(negedge inClk);
        inStart = 1'b0; inKey = rand128(); inDataBlock = rand128();
        lat = 0;
        while (outValid !== 1'b1 && lat < 40) begin
            @(negedge inClk);
            lat++;
        end
        res = outputData;
    endtask

    localparam logic [127:0] GOLD_CT = 128'hb1656851699e29fa24b70148503d2dfc;
    localparam logic [127:0] K1 = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] P1 = 128'h00112233445566778899AABBCCDDEEFF;

    initial begin
        int           lat, pulses, exp_lat;
        logic [127:0] res, k, d, last_key;
        logic [135:0] rc_lit;

        // Model pins against hand-derived values.
        rc_lit = 136'h801B366CD8AB4D9A2F5EBC63C697356AD4;
        for (int i = 0; i <= 16; i++) chk("rc_table", 128'(m_rc(i)), 128'(rc_lit[135 - 8*i -: 8]));
        chk("theta_pin", m_theta(st_t'(128'h0), st_t'({32'h1, 96'h0})),
            {32'h00000001, 32'h01000101, 32'h00000000, 32'h01000101});
        chk("gamma_pin", m_gamma(st_t'(128'h0)), {32'hffffffff, 32'hffffffff, 32'hffffffff, 32'h0});
        chk("enc_zero_vector", m_enc(128'h0, 128'h0), GOLD_CT);
        chk("model_roundtrip", m_dec(K1, m_enc(K1, P1)), P1);

        // Reset with noisy inputs.
        #1 inRstN = 1'b0;
        repeat (4) begin
            inStart = 1'b1; inKey = rand128(); inDataBlock = rand128();
            @(negedge inClk);
        end
        chk("reset_data", outputData, 128'h0);
        chk("reset_flags", {126'h0, outBusy, outValid}, 128'h0);
        inStart = 1'b0;
        inRstN  = 1'b1;
        repeat (5) @(negedge inClk);
        chk("idle_after_reset", {126'h0, outBusy, outValid}, 128'h0);

        // Golden decrypt of the all-zero vector.
        run_op(128'h0, GOLD_CT, lat, res);
        chk("golden_latency", 128'(lat), 128'd19);
        chk("golden_pt", res, 128'h0);

        // Round trip through the bench encryptor.
        run_op(K1, m_enc(K1, P1), lat, res);
        chk("roundtrip_latency", 128'(lat), 128'd19);
        chk("roundtrip_pt", res, P1);

        // Extra starts during the operation are ignored.
        k = rand128(); d = rand128();
        @(negedge inClk);
        inKey = k; inDataBlock = d; inStart = 1'b1;
        pulses = 0;
        for (int c = 0; c <= 30; c++) begin
            @(negedge inClk);
            inStart = (c == 3 || c == 10);
            inKey = rand128(); inDataBlock = rand128();
            if (outValid === 1'b1) begin
                pulses++;
                res = outputData;
            end
        end
        chk("ignored_start_pulses", 128'(pulses), 128'd1);
        chk("ignored_start_pt", res, m_dec(k, d));

        // Reset in the middle of the rounds.
        @(negedge inClk);
        inKey = rand128(); inDataBlock = rand128(); inStart = 1'b1;
        @(negedge inClk);
        inStart = 1'b0;
        repeat (9) @(negedge inClk);
        @(posedge inClk);
        #2 inRstN = 1'b0;
        @(negedge inClk);
        chk("midreset_data", outputData, 128'h0);
        chk("midreset_flags", {126'h0, outBusy, outValid}, 128'h0);
        repeat (2) @(negedge inClk);
        inRstN = 1'b1;
        pulses = 0;
        repeat (25) begin
            @(negedge inClk);
            if (outValid === 1'b1) pulses++;
        end
        chk("midreset_no_valid", 128'(pulses), 128'd0);
        k = rand128(); d = rand128();
        run_op(k, d, lat, res);
        chk("post_reset_latency", 128'(lat), 128'd19);
        chk("post_reset_pt", res, m_dec(k, d));

        // Same key twice, then a new key.
        k = rand128();
        d = rand128();
        run_op(k, d, lat, res);
        chk("samekey1_latency", 128'(lat), 128'd19);
        chk("samekey1_pt", res, m_dec(k, d));
        d = rand128();
        run_op(k, d, lat, res);
        chk("samekey2_latency", 128'(lat), CACHE ? 128'd18 : 128'd19);
        chk("samekey2_pt", res, m_dec(k, d));
        k = rand128();
        d = rand128();
        run_op(k, d, lat, res);
        chk("newkey_latency", 128'(lat), 128'd19);
        chk("newkey_pt", res, m_dec(k, d));
        last_key = k;

        // Randomized blocks with occasional key reuse and random gaps.
        for (int n = 0; n < 25; n++) begin
            k = ($urandom_range(0, 2) == 0) ? last_key : rand128();
            d = rand128();
            exp_lat = (CACHE && k == last_key) ? 18 : 19;
            run_op(k, d, lat, res);
            chk("random_latency", 128'(lat), 128'(exp_lat));
            chk("random_pt", res, m_dec(k, d));
            last_key = k;
            repeat ($urandom_range(0, 3)) @(negedge inClk);
        end

        // Start held high: back-to-back acceptance, checked by the per-cycle compare.
        repeat (70) begin
            @(negedge inClk);
            inStart = 1'b1;
            inKey = ($urandom_range(0, 1) == 0) ? last_key : rand128();
            inDataBlock = rand128();
        end
        @(negedge inClk);
        inStart = 1'b0;
        repeat (25) @(negedge inClk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/neokeon_decrypt_core.md
Name: neokeon_decrypt_core

Overview:
Iterative NOEKEON-128 decryption engine that computes one round per clock. It is the inverse-direction counterpart of the encryption datapath and reuses the same 32-bit rotate primitives (ROTL/ROTR by 8, by 1, 5 and 2). It accepts a 128-bit ciphertext and a 128-bit cipher key, derives the working key internally, runs the 16 inverse rounds plus the final Theta, and presents the plaintext with a one-cycle valid pulse. It sits between the block-cipher mode controller and the data buffer.

Parameters:
NROUNDS, 16, number of inverse rounds; only 16 is supported and the constant ROM is sized for it.
RC_INIT, 8'h80, round constant RC[0]. RC[i+1] is xtime(RC[i]) in GF(2^8) with polynomial 0x11B, giving 80,1B,36,6C,D8,AB,4D,9A,2F,5E,BC,63,C6,97,35,6A,D4.

Ports:
inClk  input  1  system clock, rising edge
inRstN  input  1  asynchronous reset, active low
inStart  input  1  start request, sampled only in IDLE
inKey  input  128  cipher key; k0=[127:96] through k3=[31:0]
inDataBlock  input  128  ciphertext; a0=[127:96] through a3=[31:0]
outBusy  output  1  high from the cycle after start is accepted until DONE
outValid  output  1  one-cycle pulse; outputData is the plaintext
outputData  output  128  plaintext, held until the next accepted start

Behaviour:
- Reset is asynchronous. The state machine goes to IDLE, all state and key registers are cleared, and outBusy, outValid and outputData are 0.
- Theta(K,a):
  - t=a0^a2; t^=ROTL8(t)^ROTR8(t); a1^=t; a3^=t.
  - a_i^=k_i.
  - t=a1^a3; t^=ROTL8(t)^ROTR8(t); a0^=t; a2^=t.
- Pi1: a1<<<1, a2<<<5, a3<<<2. Pi2 is the inverse rotations (>>>).
- Gamma, in order:
  - a1^=~a3&~a2; a0^=a2&a1
  - swap a0 and a3
  - a2^=a0^a1^a3
  - a1^=~a3&~a2; a0^=a2&a1
- Inverse round i: Theta(WK,a); a0[7:0]^=RC[i]; Pi1; Gamma; Pi2. This is combinational within one cycle.
- State machine:
  - IDLE: on inStart=1, latch key and data, go to KEYPREP.
  - KEYPREP (1 cycle): WK<=Theta(0,key). Set round counter to 16 and go to ROUND.
  - ROUND (16 cycles): apply inverse round with RC[counter], then decrement the counter. After the counter=1 round, go to FINAL.
  - FINAL (1 cycle): a<=Theta(WK,a); a0[7:0]^=RC[0]; go to DONE.
  - DONE (1 cycle): outputData<=a, outValid=1, outBusy=0, go to IDLE.
- Latency: inStart sampled at edge T gives outValid high during the cycle after edge T+19, which is 19 cycles to the result. Back-to-back throughput is one block per 20 cycles.
- inStart while outBusy=1 or in DONE is ignored. There is no queuing. Input buses are sampled only at acceptance, so later changes have no effect.
- inStart held high continuously: a new operation is accepted in IDLE on the cycle after each DONE.
- Reset asserted mid-operation aborts immediately with no outValid. outputData returns to 0.
- The round counter never wraps. Values outside 1..16 are unreachable, and if forced they go to IDLE.

Optional Feature:
Macro: NEOKEON_KEY_CACHE_EN.
- Enabled: the last latched raw key and its WK are retained. If inKey equals the cached key at acceptance, KEYPREP is skipped (IDLE goes straight to ROUND) and latency drops to 18 cycles. Reset invalidates the cache, so the first operation after reset always runs KEYPREP.
- Disabled: KEYPREP always runs, and there are no cache registers or comparator.

Test Plan:
- Reset: hold inRstN=0 with random inputs -> outBusy=0, outValid=0, outputData=128'h0. Release with inStart=0 -> stays IDLE.
- Golden decrypt: inKey=128'h0, inDataBlock=ENC_C(key=0, pt=0) from the team C model, pulse inStart -> outValid exactly 19 cycles later, outputData=128'h0.
- Round-trip: key=128'h000102030405060708090A0B0C0D0E0F, pt=128'h00112233445566778899AABBCCDDEEFF. Encrypt with the C model, decrypt -> outputData equals pt.
- Ignored start: pulse inStart again at cycles 3 and 10 with different data -> single outValid, result from the first block only.
- Mid-operation reset: assert inRstN=0 at round 8 -> no outValid, outputData=0. A new start after release yields a correct result.
- With NEOKEON_KEY_CACHE_EN: two blocks with the same key -> first latency 19, second 18, both correct. Third block with a new key -> latency 19.
